alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_INIT, 0, requester holding priority after reset (0 or 1).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_a, req0_b / req1_a, req1_b  input  8  operands of requester N.
REQ-006 req0_op / req1_op  input  3  ALU opcode of requester N.
REQ-007 req0_ready / req1_ready  output  1  requester N accepted this cycle when valid and ready are both high.
REQ-008 rsp0_valid / rsp1_valid  output  1  one-cycle pulse; response for requester N.
REQ-009 rsp_result  output  8  captured ALU result.
REQ-010 rsp_carry, rsp_sign, rsp_zero  output  1 each  captured ALU flags.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 alu_a, alu_b  output  8  operands to the shared ALU.
REQ-013 alu_opco  output  3  opcode to the shared ALU.
REQ-014 alu_power  output  1  ALU enable.
REQ-015 alu_result  input  8;  alu_carry, alu_sign, alu_zero  input  1 each  combinational ALU outputs.
REQ-016 cnt0 / cnt1  output  8  completed-operation counters (see Configuration).

Function
REQ-017 FSM states: IDLE, ISSUE, CAPTURE, RESP; IDLE->ISSUE on accept; ISSUE->CAPTURE; CAPTURE->RESP; RESP->IDLE, unconditionally.
REQ-018 reqN_ready is high only in IDLE, only for the granted requester; it is combinational from reqN_valid and the priority pointer.
REQ-019 Grant: only one valid -> grant it; both valid -> grant the priority holder; neither -> no grant.
REQ-020 After each accept, the priority pointer moves to the requester not granted.
REQ-021 On accept, operands, opcode, and requester ID are latched into internal registers; the requester may change its inputs from the next cycle.
REQ-022 alu_a, alu_b, and alu_opco drive the latched values in ISSUE and CAPTURE, and 0 otherwise.
REQ-023 alu_power is 1 in ISSUE and CAPTURE, and 0 in IDLE and RESP; the ALU is therefore power-cycled between consecutive operations.
REQ-024 On the CAPTURE clock edge, alu_result and the flags are registered into rsp_result/rsp_carry/rsp_sign/rsp_zero.
REQ-025 rspN_valid is high for exactly the RESP cycle, for the latched requester ID only.
REQ-026 Response values are held until the next capture.
REQ-027 Latency: accept at cycle T -> rspN_valid at cycle T+3; next accept no earlier than T+4; maximum throughput is 1 operation per 4 cycles.
REQ-028 Responses have no backpressure; a requester must sample at the rspN_valid pulse.
REQ-029 A request arriving while busy sees ready=0 and waits; its reqN_valid must stay high until accepted.
REQ-030 Deasserting reqN_valid before accept withdraws the request without side effects.
REQ-031 Opcodes (including 0) pass to the ALU unmodified; the arbiter does not interpret them.

Reset
REQ-032 rst has priority over all other inputs.
REQ-033 Reset values: state=IDLE, pointer=RR_INIT, latched operand/opcode/ID registers=0, all rsp_* outputs=0, cnt0=cnt1=0.
REQ-034 Outputs while rst is high: ready=0, busy=0, alu_*=0, alu_power=0.
REQ-035 Reset during ISSUE, CAPTURE, or RESP abandons the operation: no rspN_valid pulse and no counter increment.

Configuration
REQ-036 Macro ALU_ARB_STATS_EN defined: cntN increments by 1 in the RESP cycle of each requester-N response and saturates at 255.
REQ-037 Macro ALU_ARB_STATS_EN absent: cnt0 and cnt1 are constant 0, and no counter registers exist.

Verification
REQ-038 Single request: req0 a=7, b=4, op=1 with ALU giving 11 -> req0_ready at T, alu_power=1 at T+1..T+2, rsp0_valid at T+3, rsp_result=11, busy=0 at T+4.
REQ-039 Contention: both valid from reset with RR_INIT=0 -> req0 served first, req1 accepted at T+4, rsp1_valid at T+7; a third back-to-back req0 is served at T+8.
REQ-040 Flags: req1 a=250, b=10, op=1 with ALU carry=1 and result=4 -> rsp1_valid at T+3 with rsp_result=4 and rsp_carry=1; rsp0_valid stays 0.
REQ-041 Reset mid-operation: assert rst during CAPTURE -> the next cycle shows IDLE, no rsp pulse, all outputs 0, and the pending req1 is accepted after rst drops.
REQ-042 Stats (ALU_ARB_STATS_EN defined): 300 req0 operations -> cnt0=255 and cnt1=0; without the macro, cnt0=0 throughout.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// Optional build macro ALU_ARB_STATS_EN adds saturating per-requester completion counters.
module alu_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_op,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_op,
    output logic       req1_ready,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    output logic [7:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_sign,
    output logic       rsp_zero,
    output logic       busy,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_opco,
    output logic       alu_power,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_sign,
    input  logic       alu_zero,
    output logic [7:0] cnt0,
    output logic [7:0] cnt1
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0] r_state;
    logic       r_ptr;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [2:0] r_op;
    logic       r_id;
    logic [7:0] r_result;
    logic       r_carry;
    logic       r_sign;
    logic       r_zero;

    logic w_idle;
    logic w_gnt0;
    logic w_gnt1;
    logic w_acc;
    logic w_alu_on;

    // Outputs are forced quiet while rst is high, even before the reset edge lands.
    assign w_idle     = (r_state == IDLE) && !rst;
    assign w_gnt0     = req0_valid && (!req1_valid || (r_ptr == 1'b0));
    assign w_gnt1     = req1_valid && (!req0_valid || (r_ptr == 1'b1));
    assign req0_ready = w_idle && w_gnt0;
    assign req1_ready = w_idle && w_gnt1;
    assign w_acc      = req0_ready || req1_ready;

    assign w_alu_on   = !rst && ((r_state == ISSUE) || (r_state == CAPTURE));
    assign busy       = !rst && (r_state != IDLE);
    assign alu_power  = w_alu_on;
    assign alu_a      = w_alu_on ? r_a  : 8'd0;
    assign alu_b      = w_alu_on ? r_b  : 8'd0;
    assign alu_opco   = w_alu_on ? r_op : 3'd0;

    assign rsp0_valid = !rst && (r_state == RESP) && !r_id;
    assign rsp1_valid = !rst && (r_state == RESP) &&  r_id;
    assign rsp_result = r_result;
    assign rsp_carry  = r_carry;
    assign rsp_sign   = r_sign;
    assign rsp_zero   = r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= RR_INIT;
            r_a      <= 8'd0;
            r_b      <= 8'd0;
            r_op     <= 3'd0;
            r_id     <= 1'b0;
            r_result <= 8'd0;
            r_carry  <= 1'b0;
            r_sign   <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_state <= ISSUE;
                        // Priority passes to whichever requester was not granted.
                        r_ptr   <= req0_ready;
                        r_id    <= req1_ready;
                        r_a     <= req1_ready ? req1_a  : req0_a;
                        r_b     <= req1_ready ? req1_b  : req0_b;
                        r_op    <= req1_ready ? req1_op : req0_op;
                    end
                end
                ISSUE: r_state <= CAPTURE;
                CAPTURE: begin
                    r_state  <= RESP;
                    r_result <= alu_result;
                    r_carry  <= alu_carry;
                    r_sign   <= alu_sign;
                    r_zero   <= alu_zero;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [7:0] r_cnt0;
    logic [7:0] r_cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= 8'd0;
            r_cnt1 <= 8'd0;
        end else if (r_state == RESP) begin
            if (!r_id && (r_cnt0 != 8'hFF)) r_cnt0 <= r_cnt0 + 8'd1;
            if ( r_id && (r_cnt1 != 8'hFF)) r_cnt1 <= r_cnt1 + 8'd1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`else
    assign cnt0 = 8'd0;
    assign cnt1 = 8'd0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, response scoreboard, vector table
// and hand-written sequences for contention, withdrawal, mid-operation reset and counters.
module tb_alu_arbiter;
    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp_result;
    logic       rsp_carry, rsp_sign, rsp_zero;
    logic       busy;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_opco;
    logic       alu_power;
    logic [7:0] alu_result;
    logic       alu_carry, alu_sign, alu_zero;
    logic [7:0] cnt0, cnt1;

    typedef struct {
        logic       id;
        logic [7:0] r;
        logic       c;
        logic       s;
        logic       z;
    } exp_t;

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] r;
        logic       c;
        logic       s;
        logic       z;
    } vec_t;

    exp_t sb[$];
    vec_t vt[9];
    int   n_vec;
    int   n_bad;
    int   n_acc0;

    alu_arbiter #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_sign(rsp_sign), .rsp_zero(rsp_zero),
        .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opco(alu_opco), .alu_power(alu_power),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_zero(alu_zero),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {carry, sign, zero, result[7:0]}.
    function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        logic [8:0] t;
        case (op)
            3'd1:    t = {1'b0, a} + {1'b0, b};
            3'd2:    t = {1'b0, a} - {1'b0, b};
            3'd3:    t = {1'b0, a & b};
            3'd4:    t = {1'b0, a | b};
            default: t = {1'b0, a ^ b};
        endcase
        return {t[8], t[7], (t[7:0] == 8'd0), t[7:0]};
    endfunction

    always_comb begin
        {alu_carry, alu_sign, alu_zero, alu_result} = 11'd0;
        if (alu_power) {alu_carry, alu_sign, alu_zero, alu_result} = alu_f(alu_a, alu_b, alu_opco);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t       e;
        logic [10:0] m;
        if (!rst && req0_valid && req0_ready) begin
            m = alu_f(req0_a, req0_b, req0_op);
            e = '{1'b0, m[7:0], m[10], m[9], m[8]};
            sb.push_back(e);
            n_acc0++;
        end
        if (!rst && req1_valid && req1_ready) begin
            m = alu_f(req1_a, req1_b, req1_op);
            e = '{1'b1, m[7:0], m[10], m[9], m[8]};
            sb.push_back(e);
        end
        if (rsp0_valid || rsp1_valid) begin
            chk("rsp_onehot", int'(rsp0_valid & rsp1_valid), 0);
            if (sb.size() == 0) begin
                chk("sb_spurious_rsp", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_rsp", int'({rsp1_valid, rsp_carry, rsp_sign, rsp_zero, rsp_result}),
                    int'({e.id, e.c, e.s, e.z, e.r}));
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        adv();
    endtask

    task automatic drive_req(input logic id, input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] op);
        req0_valid = !id;
        req1_valid = id;
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit got;
        n_vec = 0; n_bad = 0; n_acc0 = 0;
        vt[0] = '{1'b0, 8'd7,   8'd4,   3'd1, 8'd11,  1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 8'd250, 8'd10,  3'd1, 8'd4,   1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b0, 8'd5,   8'd5,   3'd2, 8'd0,   1'b0, 1'b0, 1'b1};
        vt[3] = '{1'b1, 8'd3,   8'd5,   3'd2, 8'd254, 1'b1, 1'b1, 1'b0};
        vt[4] = '{1'b0, 8'hF0,  8'h3C,  3'd3, 8'h30,  1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b1, 8'h80,  8'h01,  3'd4, 8'h81,  1'b0, 1'b1, 1'b0};
        vt[6] = '{1'b0, 8'hAA,  8'hAA,  3'd0, 8'h00,  1'b0, 1'b0, 1'b1};
        vt[7] = '{1'b1, 8'h12,  8'h34,  3'd7, 8'h26,  1'b0, 1'b0, 1'b0};
        vt[8] = '{1'b0, 8'd255, 8'd1,   3'd1, 8'd0,   1'b1, 1'b0, 1'b1};

        // Reset with both requesters pending, then contention from reset.
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 8'd9;   req0_b = 8'd3;  req0_op = 3'd2;
        req1_valid = 1'b1; req1_a = 8'd100; req1_b = 8'd27; req1_op = 3'd1;
        cyc();
        sample();
        chk("rst_ready0", int'(req0_ready), 0);
        chk("rst_ready1", int'(req1_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_alu", int'({alu_power, alu_opco, alu_a, alu_b}), 0);
        chk("rst_rsp", int'({rsp0_valid, rsp1_valid, rsp_carry, rsp_sign, rsp_zero, rsp_result}), 0);
        chk("rst_cnt", int'({cnt0, cnt1}), 0);
        adv();
        rst = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            sample();
            chk("cont_ready0", int'(req0_ready), int'(c == 0 || c == 8));
            chk("cont_ready1", int'(req1_ready), int'(c == 4));
            chk("cont_rsp0", int'(rsp0_valid), int'(c == 3));
            chk("cont_rsp1", int'(rsp1_valid), int'(c == 7));
            adv();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int c = 0; c < 4; c++) cyc();

        // Single-request vector table; operands are scrambled right after accept.
        for (int i = 0; i < 9; i++) begin
            drive_req(vt[i].id, vt[i].a, vt[i].b, vt[i].op);
            sample();
            chk("tbl_ready", int'(vt[i].id ? req1_ready : req0_ready), 1);
            chk("tbl_ready_other", int'(vt[i].id ? req0_ready : req1_ready), 0);
            adv();
            req0_valid = 1'b0; req1_valid = 1'b0;
            req0_a = ~vt[i].a; req0_b = ~vt[i].b; req0_op = ~vt[i].op;
            req1_a = ~vt[i].a; req1_b = ~vt[i].b; req1_op = ~vt[i].op;
            got = 1'b0;
            for (int k = 1; k <= 6 && !got; k++) begin
                sample();
                if (rsp0_valid || rsp1_valid) begin
                    got = 1'b1;
                    chk("tbl_latency", k, 3);
                    chk("tbl_rsp_id", int'(rsp1_valid), int'(vt[i].id));
                    chk("tbl_result", int'(rsp_result), int'(vt[i].r));
                    chk("tbl_flags", int'({rsp_carry, rsp_sign, rsp_zero}),
                        int'({vt[i].c, vt[i].s, vt[i].z}));
                    chk("tbl_power_resp", int'(alu_power), 0);
                end else begin
                    chk("tbl_power", int'(alu_power), 1);
                end
                adv();
            end
            if (!got) chk("tbl_timeout", 0, 1);
            sample();
            chk("tbl_busy_done", int'(busy), 0);
            chk("tbl_result_held", int'(rsp_result), int'(vt[i].r));
            adv();
        end

        // A request raised while busy and withdrawn before accept leaves no trace.
        drive_req(1'b0, 8'd40, 8'd2, 3'd1);
        sample();
        chk("wd_ready0", int'(req0_ready), 1);
        adv();
        drive_req(1'b1, 8'd77, 8'd66, 3'd3);
        sample();
        chk("wd_ready1_busy", int'(req1_ready), 0);
        adv();
        req1_valid = 1'b0;
        for (int c = 0; c < 5; c++) cyc();
        chk("wd_sb_empty", sb.size(), 0);

        // Reset during CAPTURE abandons the op; pending req1 is taken right after.
        drive_req(1'b0, 8'd20, 8'd22, 3'd1);
        sample();
        chk("mr_ready0", int'(req0_ready), 1);
        adv();
        drive_req(1'b1, 8'd13, 8'd14, 3'd4);
        cyc();
        rst = 1'b1;
        sample();
        chk("mr_rst_busy", int'(busy), 0);
        chk("mr_rst_alu", int'({alu_power, alu_opco, alu_a, alu_b}), 0);
        chk("mr_rst_ready1", int'(req1_ready), 0);
        adv();
        rst = 1'b0;
        sb.delete();
        sample();
        chk("mr_no_rsp", int'({rsp0_valid, rsp1_valid}), 0);
        chk("mr_rsp_cleared", int'({rsp_carry, rsp_sign, rsp_zero, rsp_result}), 0);
        chk("mr_idle", int'({busy, alu_power}), 0);
        chk("mr_req1_taken", int'(req1_ready), 1);
        adv();
        req1_valid = 1'b0;
        for (int c = 0; c < 4; c++) cyc();
        chk("mr_sb_empty", sb.size(), 0);

        // Counter saturation over 300 back-to-back req0 operations.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_acc0 = 0;
        req0_valid = 1'b1;
        for (int c = 0; c < 1400 && n_acc0 < 300; c++) begin
            req0_a  = 8'($urandom_range(0, 255));
            req0_b  = 8'($urandom_range(0, 255));
            req0_op = 3'($urandom_range(0, 7));
            cyc();
        end
        req0_valid = 1'b0;
        chk("st_accepts", n_acc0, 300);
        for (int c = 0; c < 5; c++) cyc();
`ifdef ALU_ARB_STATS_EN
        chk("st_cnt0", int'(cnt0), 255);
`else
        chk("st_cnt0", int'(cnt0), 0);
`endif
        chk("st_cnt1", int'(cnt1), 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
